// File: rtl/prog_loader.sv
// Boot-time program loader: turns a 32-bit valid/ready word stream into CPU imem/dmem writes, then enables the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum beat before the CPU is enabled.
module prog_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    input  logic        restart,
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic [63:0] dmem_wdata,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error,
    output logic [1:0]  err_code
);
    localparam int IW = $clog2(IMEM_DEPTH) + 1;
    localparam int DW = $clog2(DMEM_DEPTH) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_IMEM    = 3'd1;
    localparam logic [2:0] S_DMEM_LO = 3'd2;
    localparam logic [2:0] S_DMEM_HI = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM    = 3'd4;
    localparam logic [2:0] S_FIN     = S_CSUM;
`else
    localparam logic [2:0] S_FIN     = S_RUN;
`endif

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] ni_q, ni_d, icnt_q, icnt_d, iaddr_q, iaddr_d;
    logic [DW-1:0] nd_q, nd_d, dcnt_q, dcnt_d, daddr_q, daddr_d;
    logic [31:0]   lo_q, lo_d, idata_q, idata_d;
    logic [63:0]   ddata_q, ddata_d;
    logic          iwen_q, iwen_d, dwen_q, dwen_d, en_q, en_d;
    logic [1:0]    err_q, err_d;
    logic          acc;

    assign s_ready    = (state_q != S_RUN) && (state_q != S_ERROR);
    assign busy       = s_ready && (state_q != S_IDLE);
    assign error      = (state_q == S_ERROR);
    assign err_code   = err_q;
    assign cpu_enable = en_q;
    assign acc        = s_valid && s_ready;

    assign imem_addr  = {{(62-IW){1'b0}}, iaddr_q, 2'b00};
    assign imem_wen   = iwen_q;
    assign imem_wdata = idata_q;
    assign dmem_addr  = {{(61-DW){1'b0}}, daddr_q, 3'b000};
    assign dmem_wen   = dwen_q;
    assign dmem_wdata = ddata_q;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] xor_q, xor_d;

    always_comb begin
        xor_d = xor_q;
        if (acc && state_q == S_IDLE) begin
            xor_d = s_data;
        end else if (acc && state_q != S_CSUM) begin
            xor_d = xor_q ^ s_data;
        end else if (restart && !s_ready) begin
            xor_d = '0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) xor_q <= '0;
        else      xor_q <= xor_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        ni_d    = ni_q;
        nd_d    = nd_q;
        icnt_d  = icnt_q;
        dcnt_d  = dcnt_q;
        lo_d    = lo_q;
        iwen_d  = 1'b0;
        iaddr_d = iaddr_q;
        idata_d = idata_q;
        dwen_d  = 1'b0;
        daddr_d = daddr_q;
        ddata_d = ddata_q;
        err_d   = err_q;
        // Registered enable lags the RUN state by one edge so it never overlaps the last write.
        en_d    = (state_q == S_RUN) && !restart;
        case (state_q)
            S_IDLE: if (acc) begin
                ni_d   = s_data[IW-1:0];
                nd_d   = s_data[16 +: DW];
                icnt_d = '0;
                dcnt_d = '0;
                if ({16'd0, s_data[15:0]} > 32'(IMEM_DEPTH) ||
                    {16'd0, s_data[31:16]} > 32'(DMEM_DEPTH)) begin
                    state_d = S_ERROR;
                    err_d   = 2'b01;
                end else if (s_data[15:0] != 16'd0) begin
                    state_d = S_IMEM;
                end else if (s_data[31:16] != 16'd0) begin
                    state_d = S_DMEM_LO;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_IMEM: if (acc) begin
                iwen_d  = 1'b1;
                iaddr_d = icnt_q;
                idata_d = s_data;
                icnt_d  = icnt_q + 1'b1;
                if (icnt_d == ni_q) state_d = (nd_q != '0) ? S_DMEM_LO : S_FIN;
            end
            S_DMEM_LO: if (acc) begin
                lo_d    = s_data;
                state_d = S_DMEM_HI;
            end
            S_DMEM_HI: if (acc) begin
                dwen_d  = 1'b1;
                daddr_d = dcnt_q;
                ddata_d = {s_data, lo_q};
                dcnt_d  = dcnt_q + 1'b1;
                state_d = (dcnt_d == nd_q) ? S_FIN : S_DMEM_LO;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (acc) begin
                if (s_data == xor_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_ERROR;
                    err_d   = 2'b10;
                end
            end
`endif
            S_RUN, S_ERROR: if (restart) begin
                state_d = S_IDLE;
                icnt_d  = '0;
                dcnt_d  = '0;
                err_d   = 2'b00;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            ni_q    <= '0;
            nd_q    <= '0;
            icnt_q  <= '0;
            dcnt_q  <= '0;
            lo_q    <= '0;
            iwen_q  <= 1'b0;
            iaddr_q <= '0;
            idata_q <= '0;
            dwen_q  <= 1'b0;
            daddr_q <= '0;
            ddata_q <= '0;
            err_q   <= 2'b00;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ni_q    <= ni_d;
            nd_q    <= nd_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            lo_q    <= lo_d;
            iwen_q  <= iwen_d;
            iaddr_q <= iaddr_d;
            idata_q <= idata_d;
            dwen_q  <= dwen_d;
            daddr_q <= daddr_d;
            ddata_q <= ddata_d;
            err_q   <= err_d;
            en_q    <= en_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: beat-index reference model compared every cycle, plus directed literal checks.
module tb_prog_loader;
    localparam int IMEM_DEPTH = 512;
    localparam int DMEM_DEPTH = 1024;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        restart = 1'b0;
    logic        s_ready, imem_wen, dmem_wen, cpu_enable, busy, error;
    logic [63:0] imem_addr, dmem_addr, dmem_wdata;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;

    prog_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .clk(clk), .arst(arst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .restart(restart), .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .cpu_enable(cpu_enable), .busy(busy), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=loading 2=run 3=error; k counts beats of the current image.
    int          mode, k, ni, nd;
    logic [31:0] xacc, lo;
    logic [1:0]  ecode;
    logic        e_iwen, e_dwen, e_en;
    logic [63:0] e_iaddr, e_daddr, e_ddata;
    logic [31:0] e_idata;

    task automatic model_reset();
        mode = 0; k = 0; ni = 0; nd = 0; xacc = '0; lo = '0; ecode = 2'b00;
        e_iwen = 1'b0; e_dwen = 1'b0; e_en = 1'b0;
        e_iaddr = '0; e_daddr = '0; e_ddata = '0; e_idata = '0;
    endtask

    task automatic model_step(input logic sv, input logic [31:0] d, input logic rs);
        int p;
        int off;
        bit acc;
        acc = sv && (mode == 0 || mode == 1);
        e_iwen = 1'b0;
        e_dwen = 1'b0;
        e_en = (mode == 2) && !rs;
        if ((mode == 2 || mode == 3) && rs) begin
            mode = 0; ecode = 2'b00; k = 0;
        end else if (acc) begin
            if (mode == 0) begin
                ni = int'(d[15:0]);
                nd = int'(d[31:16]);
                xacc = d;
                k = 1;
                if (ni > IMEM_DEPTH || nd > DMEM_DEPTH) begin
                    mode = 3; ecode = 2'b01;
                end else begin
                    mode = 1;
                end
            end else begin
                p = ni + 2 * nd;
                if (k <= ni) begin
                    e_iwen = 1'b1; e_iaddr = 64'(4 * (k - 1)); e_idata = d; xacc ^= d;
                end else if (k <= p) begin
                    off = k - ni - 1;
                    if (off % 2 == 0) lo = d;
                    else begin
                        e_dwen = 1'b1; e_daddr = 64'(8 * (off / 2)); e_ddata = {d, lo};
                    end
                    xacc ^= d;
                end else if (d == xacc) begin
                    mode = 2;
                end else begin
                    mode = 3; ecode = 2'b10;
                end
                k++;
            end
            if (mode == 1 && k == ni + 2 * nd + 1 && !CSUM) mode = 2;
        end
    endtask

    always @(posedge clk) begin
        if (arst) model_reset();
        else model_step(s_valid, s_data, restart);
        #1;
        chk("cyc_s_ready", 64'(s_ready), 64'(mode == 0 || mode == 1));
        chk("cyc_busy", 64'(busy), 64'(mode == 1));
        chk("cyc_error", 64'(error), 64'(mode == 3));
        chk("cyc_err_code", 64'(err_code), 64'(ecode));
        chk("cyc_cpu_enable", 64'(cpu_enable), 64'(e_en));
        chk("cyc_imem_wen", 64'(imem_wen), 64'(e_iwen));
        chk("cyc_imem_addr", imem_addr, e_iaddr);
        chk("cyc_imem_wdata", 64'(imem_wdata), 64'(e_idata));
        chk("cyc_dmem_wen", 64'(dmem_wen), 64'(e_dwen));
        chk("cyc_dmem_addr", dmem_addr, e_daddr);
        chk("cyc_dmem_wdata", dmem_wdata, e_ddata);
    end

    task automatic beat_r(input logic [31:0] d, input logic r);
        @(negedge clk);
        s_valid = 1'b1; s_data = d; restart = r;
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [31:0] d);
        beat_r(d, 1'b0);
    endtask

    task automatic step(input logic noisy);
        @(negedge clk);
        s_valid = noisy ? 1'($urandom % 2) : 1'b0;
        s_data = $urandom;
        restart = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic do_restart();
        @(negedge clk);
        s_valid = 1'b0; restart = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic csum(input logic [31:0] x);
        if (CSUM) beat(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, hdr, w;
        int rni, rnd;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("reset_s_ready", 64'(s_ready), 64'd1);
        chk("reset_cpu_enable", 64'(cpu_enable), 64'd0);

        // Header only
        beat(32'h0000_0000);
        csum(32'h0000_0000);
        chk("hdr_only_en_early", 64'(cpu_enable), 64'd0);
        gap(1);
        chk("hdr_only_en", 64'(cpu_enable), 64'd1);
        do_restart();

        // Instructions only
        beat(32'h0000_0002);
        beat(32'h0050_0093);
        chk("imem0_wen", 64'(imem_wen), 64'd1);
        chk("imem0_addr", imem_addr, 64'h0);
        chk("imem0_data", 64'(imem_wdata), 64'h0050_0093);
        beat(32'h0010_8133);
        chk("imem1_addr", imem_addr, 64'h4);
        chk("imem1_data", 64'(imem_wdata), 64'h0010_8133);
        chk("imem1_en_low", 64'(cpu_enable), 64'd0);
        csum(32'h0040_81A2);
        gap(1);
        chk("imem_run_en", 64'(cpu_enable), 64'd1);
        chk("imem_run_wen", 64'(imem_wen), 64'd0);
        do_restart();
        chk("restart_en_low", 64'(cpu_enable), 64'd0);

        // Data only with gaps
        beat(32'h0001_0000);
        beat(32'h89AB_CDEF);
        chk("dmem_lo_no_wen", 64'(dmem_wen), 64'd0);
        gap(3);
        beat(32'h0123_4567);
        chk("dmem_wen", 64'(dmem_wen), 64'd1);
        chk("dmem_addr", dmem_addr, 64'h0);
        chk("dmem_data", dmem_wdata, 64'h0123_4567_89AB_CDEF);
        csum(32'h0001_0000 ^ 32'h89AB_CDEF ^ 32'h0123_4567);
        gap(2);
        do_restart();

        // Size overflow on either count
        beat(32'(IMEM_DEPTH + 1));
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_code", 64'(err_code), 64'd1);
        chk("ovf_ready", 64'(s_ready), 64'd0);
        chk("ovf_no_wen", 64'(imem_wen), 64'd0);
        gap(2);
        do_restart();
        chk("ovf_restart_ready", 64'(s_ready), 64'd1);
        chk("ovf_restart_code", 64'(err_code), 64'd0);
        beat(32'(DMEM_DEPTH + 1) << 16);
        chk("ovf_d_code", 64'(err_code), 64'd1);
        do_restart();

        // Checksum pass and fail
        if (CSUM) begin
            beat(32'h0000_0001); beat(32'h0000_0013); beat(32'h0000_0012);
            gap(1);
            chk("csum_ok_en", 64'(cpu_enable), 64'd1);
            do_restart();
            beat(32'h0000_0001); beat(32'h0000_0013); beat(32'h0000_0000);
            chk("csum_bad_code", 64'(err_code), 64'd2);
            gap(1);
            chk("csum_bad_en", 64'(cpu_enable), 64'd0);
            do_restart();
        end

        // Reset mid-load, then a full image
        beat(32'h0000_0003);
        beat(32'h0000_0011);
        @(negedge clk);
        s_valid = 1'b0; arst = 1'b1;
        #1;
        chk("arst_imem_wen", 64'(imem_wen), 64'd0);
        chk("arst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        arst = 1'b0;
        beat(32'h0000_0003);
        beat(32'hAAAA_0001); beat(32'hBBBB_0002); beat(32'hCCCC_0003);
        chk("reload_addr", imem_addr, 64'h8);
        chk("reload_data", 64'(imem_wdata), 64'hCCCC_0003);
        csum(32'h0000_0003 ^ 32'hAAAA_0001 ^ 32'hBBBB_0002 ^ 32'hCCCC_0003);
        gap(1);
        chk("reload_en", 64'(cpu_enable), 64'd1);
        do_restart();

        // Exactly-full instruction memory is legal
        x = 32'(IMEM_DEPTH);
        beat(x);
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            w = $urandom;
            x ^= w;
            beat(w);
        end
        chk("full_last_addr", imem_addr, 64'(4 * (IMEM_DEPTH - 1)));
        csum(x);
        gap(2);
        chk("full_en", 64'(cpu_enable), 64'd1);
        do_restart();

        // Randomized images with gaps, ignored restarts and corrupted checksums
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                hdr = ($urandom % 2 == 1) ? 32'(IMEM_DEPTH + 1 + $urandom_range(0, 100))
                                          : (32'(DMEM_DEPTH + 1 + $urandom_range(0, 100)) << 16);
                beat(hdr);
            end else begin
                rni = $urandom_range(0, 6);
                rnd = $urandom_range(0, 4);
                hdr = {16'(rnd), 16'(rni)};
                x = hdr;
                beat(hdr);
                for (int i = 0; i < rni + 2 * rnd; i++) begin
                    if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
                    w = $urandom;
                    x ^= w;
                    beat_r(w, 1'($urandom_range(0, 3) == 0));
                end
                csum(($urandom_range(0, 3) == 0) ? (x ^ 32'h1) : x);
            end
            repeat ($urandom_range(1, 4)) step(1'b1);
            do_restart();
        end
        gap(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the `cpu` top. It accepts a 32-bit valid/ready word stream (host/debug link) and drives the CPU's external instruction-memory and data-memory write ports (`addr_ext`/`wen_ext`/`wdata_ext`, `addr_ext_2`/`wen_ext_2`/`wdata_ext_2`). After the image is written, it raises `cpu_enable`. The CPU's `enable` must stay low while any write is in flight.

## Interface
- `IMEM_DEPTH`, 512: instruction-memory capacity in 32-bit words.
- `DMEM_DEPTH`, 1024: data-memory capacity in 64-bit words.
- `clk` input 1: single clock, rising edge.
- `arst` input 1: asynchronous, active-high reset.
- `s_valid` input 1: stream word valid.
- `s_data` input 32: stream word.
- `s_ready` output 1: loader accepts the word; a transfer happens on a clock edge with `s_valid && s_ready`.
- `restart` input 1: synchronous; returns the loader from RUN/ERROR to IDLE.
- `imem_addr` output 64: byte address to `addr_ext`.
- `imem_wen` output 1: drives `wen_ext`.
- `imem_wdata` output 32: drives `wdata_ext`.
- `dmem_addr` output 64: byte address to `addr_ext_2`.
- `dmem_wen` output 1: drives `wen_ext_2`.
- `dmem_wdata` output 64: drives `wdata_ext_2`.
- `cpu_enable` output 1: drives the CPU `enable`.
- `busy` output 1: high in any state other than IDLE, RUN or ERROR.
- `error` output 1: high in ERROR.
- `err_code` output 2: 01 = size overflow, 10 = checksum mismatch, 00 otherwise.

## Operation
- **Header:** first beat. `[15:0]` = NI, the instruction word count. `[31:16]` = ND, the data dword count.
- **IDLE:** `s_ready`=1. Accepting a beat latches the header.
  - NI > IMEM_DEPTH or ND > DMEM_DEPTH → ERROR with code 01.
  - Otherwise → IMEM if NI≠0, else DMEM_LO if ND≠0, else FINISH.
- **IMEM:** each accepted beat i (0..NI-1) writes `imem_wdata`=beat to `imem_addr`=4·i. After beat NI-1 → DMEM_LO if ND≠0, else FINISH.
- **DMEM_LO:** the accepted beat is held as the low half → DMEM_HI.
- **DMEM_HI:** the accepted beat is the high half. Write `{hi,lo}` to `dmem_addr`=8·j. Then → DMEM_LO if j<ND-1, else FINISH.
- **FINISH:** a pseudo-state that resolves to CSUM (macro on) or RUN (macro off). It is not visible as a cycle.
- **RUN:** `cpu_enable`=1, `s_ready`=0. Incoming beats are ignored.
- **ERROR:** `cpu_enable`=0, `s_ready`=0, `err_code` held.
- **restart:** in RUN/ERROR → IDLE, clearing counters and `err_code`. Ignored in IDLE and in loading states.
- `s_ready` is 1 in IDLE, IMEM, DMEM_LO, DMEM_HI and CSUM, with no backpressure. The memories accept one write per cycle.
- Address counters are `$clog2(depth)`+1 bits, zero-extended into the 64-bit addresses. Upper bits are always 0.

## Timing
- **Reset:** state IDLE. All outputs 0 except `s_ready`=1. Counters, header, low-half and checksum registers cleared.
- Reset mid-load drops the partial image. No further writes are issued, and `cpu_enable` stays 0.
- Write outputs are registered. A beat accepted at edge N produces `*_wen`=1 with valid addr/wdata for exactly the cycle after N. Otherwise `wen`=0.
- Back-to-back beats give back-to-back one-cycle writes. Gaps in `s_valid` give gaps in `wen`.
- `addr` and `wdata` hold their last values while `wen`=0.
- `cpu_enable` rises in the cycle after the last write cycle, i.e. one cycle after the final beat's edge. It is never high in the same cycle as any `wen`.
- `restart` in RUN: `cpu_enable` falls at the next edge.
- Error transitions take effect at the edge that accepts the offending beat. No write is issued for that beat.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - A running 32-bit XOR covers the header and all payload beats.
  - After the payload, the loader waits in CSUM for one beat.
  - Beat equal to the XOR → RUN.
  - Otherwise → ERROR with code 10. Memory contents stay written, and `cpu_enable` stays 0.
- **Not defined:** no CSUM state and no XOR register. FINISH goes straight to RUN, and `err_code` 10 never occurs.

## Test plan
- **Header only:** header 0x0000_0000 (plus checksum 0x0000_0000 if enabled) → no `wen` pulses. `cpu_enable`=1 one cycle after the last beat.
- **Instructions only:** header 0x0000_0002, beats 0x00500093 and 0x00108133 → `imem_wen` pulses at addr 0x0 then 0x4 with those data. `dmem_wen` never pulses. Then `cpu_enable`=1.
- **Data only, with gaps:** header 0x0001_0000, beats 0x89ABCDEF then 0x01234567 with 3 idle cycles between → one `dmem_wen` at addr 0x0 with data 0x0123456789ABCDEF, asserted only after the second beat.
- **Overflow:** header with NI=IMEM_DEPTH+1 → ERROR, `err_code`=01, no writes. `restart` → IDLE with `s_ready`=1.
- **Checksum (macro on):** header 0x0000_0001 and beat 0x0000_0013.
  - Checksum 0x0000_0012 → RUN.
  - Checksum 0x0000_0000 → ERROR with code 10, `cpu_enable`=0.
- **Reset mid-load:** assert `arst` after 1 of 3 instruction beats → all outputs go to reset values immediately. A new full image then loads correctly.
